// File: rtl/seg_display_ctrl.sv
// Multi-digit seven-segment controller: load/shift, BCD count up/down, rotate, registered glyphs.
// Optional leading-zero blanking is compiled in with `define SEG_BLANK_LEADING_ZERO_EN.
module seg_display_ctrl #(
  parameter int DIGITS   = 5,
  parameter int TICK_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            mode,
  input  logic [3:0]            digit_in,
  input  logic                  digit_load,
  input  logic                  run,
  input  logic                  clear,
  output logic [8*DIGITS-1:0]   seg,
  output logic                  done,
  output logic                  wrap
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CntMax = CW'(TICK_DIV - 1);

  localparam logic [1:0] ModeStatic = 2'd0;
  localparam logic [1:0] ModeUp     = 2'd1;
  localparam logic [1:0] ModeDown   = 2'd2;
  localparam logic [1:0] ModeScroll = 2'd3;

  logic [CW-1:0]              r_cnt;
  logic [DIGITS-1:0][3:0]     r_d;
  logic                       r_load_prev;
  logic                       r_armed;
  logic [1:0]                 r_mode_prev;
  logic                       r_done;
  logic                       r_wrap_pend;
  logic                       r_wrap;
  logic [8*DIGITS-1:0]        r_seg;

  logic [CW-1:0]              w_cnt_next;
  logic [DIGITS-1:0][3:0]     w_d_next;
  logic [DIGITS-1:0][3:0]     w_inc;
  logic [DIGITS-1:0][3:0]     w_dec;
  logic                       w_inc_wrap;
  logic                       w_done_next;
  logic                       w_wrap_next;
  logic [8*DIGITS-1:0]        w_seg_next;
  logic                       w_mode_chg;
  logic                       w_load;
  logic                       w_tick;
  logic [3:0]                 w_load_val;

  function automatic logic [7:0] glyph(input logic [3:0] v);
    logic [7:0] g;
    case (v)
      4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
      4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
      4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
      4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
    endcase
    return g;
  endfunction

  function automatic logic [8*DIGITS-1:0] seg_reset();
    logic [8*DIGITS-1:0] v;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    v = {8*DIGITS{1'b1}};
    v[7:0] = 8'hC0;
`else
    v = {DIGITS{8'hC0}};
`endif
    return v;
  endfunction

  // Edge detection is disarmed for the first cycle after reset so a held-high load is ignored.
  assign w_mode_chg = (mode != r_mode_prev);
  assign w_load     = digit_load & ~r_load_prev & r_armed;
  assign w_tick     = run && (mode != ModeStatic) && !w_mode_chg && (r_cnt == CntMax);
  assign w_load_val = (((mode == ModeUp) || (mode == ModeDown)) && (digit_in > 4'd9)) ?
                      4'd0 : digit_in;

  always_comb begin
    w_cnt_next = r_cnt;
    if (clear || (mode == ModeStatic) || w_mode_chg) begin
      w_cnt_next = '0;
    end else if (run) begin
      w_cnt_next = (r_cnt == CntMax) ? '0 : r_cnt + CW'(1);
    end
  end

  always_comb begin : p_arith
    logic v_carry;
    logic v_borrow;
    w_inc    = r_d;
    w_dec    = r_d;
    v_carry  = 1'b1;
    v_borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (v_carry) begin
        if (r_d[k] >= 4'd9) begin
          w_inc[k] = 4'd0;
        end else begin
          w_inc[k] = r_d[k] + 4'd1;
          v_carry  = 1'b0;
        end
      end
      if (v_borrow) begin
        if (r_d[k] == 4'd0) begin
          w_dec[k] = 4'd9;
        end else begin
          w_dec[k] = r_d[k] - 4'd1;
          v_borrow = 1'b0;
        end
      end
    end
    w_inc_wrap = v_carry;
  end

  always_comb begin
    w_d_next    = r_d;
    w_done_next = r_done && !w_mode_chg;
    w_wrap_next = 1'b0;
    if (clear) begin
      w_d_next    = '0;
      w_done_next = 1'b0;
    end else if (w_load) begin
      for (int k = 1; k < DIGITS; k++) begin
        w_d_next[k] = r_d[k-1];
      end
      w_d_next[0] = w_load_val;
      w_done_next = 1'b0;
    end else if (w_tick) begin
      case (mode)
        ModeUp: begin
          w_d_next    = w_inc;
          w_wrap_next = w_inc_wrap;
        end
        ModeDown: begin
          // Count-down saturates at zero rather than wrapping to all-9.
          if (r_d == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_d_next = w_dec;
            if (w_dec == '0) w_done_next = 1'b1;
          end
        end
        ModeScroll: begin
          for (int k = 1; k < DIGITS; k++) begin
            w_d_next[k] = r_d[k-1];
          end
          w_d_next[0] = r_d[DIGITS-1];
        end
        default: ;
      endcase
    end
  end

  always_comb begin : p_glyph
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_seg_next   = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_seg_next[8*k +: 8] = glyph(r_d[k]);
`ifdef SEG_BLANK_LEADING_ZERO_EN
      v_zero_above = v_zero_above && (r_d[k] == 4'd0);
      if ((k != 0) && v_zero_above) w_seg_next[8*k +: 8] = 8'hFF;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_d         <= '0;
      r_load_prev <= 1'b0;
      r_armed     <= 1'b0;
      r_mode_prev <= 2'd0;
      r_done      <= 1'b0;
      r_wrap_pend <= 1'b0;
      r_wrap      <= 1'b0;
      r_seg       <= seg_reset();
    end else begin
      r_cnt       <= w_cnt_next;
      r_d         <= w_d_next;
      r_load_prev <= digit_load;
      r_armed     <= 1'b1;
      r_mode_prev <= mode;
      r_done      <= w_done_next;
      // Wrap is delayed one stage so it lines up with the all-zero glyphs.
      r_wrap_pend <= w_wrap_next;
      r_wrap      <= r_wrap_pend;
      r_seg       <= w_seg_next;
    end
  end

  assign seg  = r_seg;
  assign done = r_done;
  assign wrap = r_wrap;

endmodule
